// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, FSM encoding and baud helpers
// for the buffered UART transmitter.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic int bit_cnt_max(int clk_hz, int baud);
    return clk_hz / baud;
  endfunction

  // Counter holds 0..cnt_max-1.
  function automatic int bit_cnt_width(int cnt_max);
    return (cnt_max > 2) ? $clog2(cnt_max) : 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock show-ahead FIFO with level output;
// pushes while full and pops while empty are dropped.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign level = cnt_q;
  assign rdata = mem_q[rd_q];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push)
                    - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered LSB-first UART transmitter with
// configurable data bits, parity, stop bits and baud.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FEQ    = 50_000_000,
  parameter int UART_BOT   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        data_in,
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  output logic                        uart_tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int BIT_CNT_MAX = bit_cnt_max(CLK_FEQ, UART_BOT);
  localparam int CW = bit_cnt_width(BIT_CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CNT_MAX - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full, fifo_empty;
  logic                 load, tick;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_in_valid),
    .wdata (data_in),
    .pop   (load),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign data_in_ready = !fifo_full;
  assign uart_tx       = tx_q;
  assign busy          = busy_q;
  assign tick          = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    load    = 1'b0;
    cnt_d   = (state_q == ST_IDLE || tick) ?
              '0 : cnt_q + CW'(1);
    unique case (state_q)
      ST_IDLE: load = !fifo_empty;
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_q != STOP_LAST) begin
            bit_d = bit_q + 4'd1;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Pop and start bit share one edge, so frames abut.
    if (load) begin
      state_d = ST_START;
      shift_d = fifo_rdata;
      par_d   = (PARITY == PAR_ODD) ?
                ~^fifo_rdata : ^fifo_rdata;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter; the successor to the fixed 8N1 transmitter used by the control/debug link. It accepts words over a valid/ready handshake into an internal FIFO and serialises them LSB-first. Data width, parity mode, stop-bit count, baud and buffer depth are all configurable. Frames go out back-to-back with no idle gap while the FIFO holds data.

## Interface
- CLK_FEQ, 50_000_000: system clock frequency, Hz.
- UART_BOT, 115200: baud rate; BIT_CNT_MAX = CLK_FEQ / UART_BOT (integer division, truncated), must be ≥ 4.
- DATA_BITS, 8: data bits per frame, legal 5–9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: legal 1 or 2.
- FIFO_DEPTH, 16: entries; power of two, ≥ 2.
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, asynchronous assert, active-low.
- data_in  in  DATA_BITS  word to transmit.
- data_in_valid  in  1  data_in is valid this cycle.
- data_in_ready  out  1  FIFO can accept; equals !full (combinational from state).
- uart_tx  out  1  serial line, registered, idle high.
- busy  out  1  a frame is on the line.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently buffered.

## Operation
- Reset values: uart_tx = 1, busy = 0, fifo_level = 0, data_in_ready = 1. FIFO and FSM are cleared and the baud counter is 0.
- Push: on a clk edge with data_in_valid & data_in_ready. A push while full is ignored; the source must hold the word. Pushes and pops in the same cycle are both honoured and leave the level unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE with FIFO non-empty: pop, latch the word into the shift register, go to START. uart_tx <= 0 and busy <= 1 on the same edge.
- START: lasts one bit time, then DATA.
- DATA: DATA_BITS bit times, LSB first.
- After DATA: go to PARITY if PARITY != 0, else STOP.
- PARITY bit value:
  - odd mode: ~^word.
  - even mode: ^word.
- STOP: STOP_BITS bit times, uart_tx = 1.
- End of the last stop bit:
  - FIFO non-empty: pop and enter START on the same edge (no idle cycle).
  - FIFO empty: go to IDLE, busy <= 0.
- The baud counter runs 0..BIT_CNT_MAX-1 only while not in IDLE. The bit advances when the count reaches BIT_CNT_MAX-1. The counter is wide enough for BIT_CNT_MAX-1.
- data_in is captured at pop. A later change to a FIFO entry's source has no effect on the frame in flight.
- Reset asserted mid-frame: uart_tx goes high immediately (asynchronously), the frame is abandoned and buffered words are discarded.

## Timing
- Bit time is exactly BIT_CNT_MAX clk cycles.
- Frame length is (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × BIT_CNT_MAX cycles.
- Latency: a word pushed into an empty FIFO while in IDLE at edge k drives uart_tx low from edge k+1.
- fifo_level updates on the edge after a push or pop.
- data_in_ready falls in the cycle fifo_level becomes FIFO_DEPTH and rises in the cycle after a pop from full.
- busy is high continuously across back-to-back frames.

## Structure
- Package uart_pkg:
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - FSM state encoding;
  - a function computing BIT_CNT_MAX and its counter width.
- Sub-module uart_sync_fifo, parametrised by width and depth:
  - single clock, async active-low reset;
  - full/empty flags and level output;
  - show-ahead read data.
- FSM, baud counter, shift register and parity logic live in uart_tx_fifo.

## Test plan
- Defaults 8N1, BIT_CNT_MAX=434; push 0x55 -> uart_tx low at push+1 cycle, bits 1,0,1,0,1,0,1,0 each 434 cycles, stop high, busy falls after 4340 cycles.
- DATA_BITS=7, PARITY=2 (even), STOP_BITS=2; push 0x03 -> parity bit 0, frame 11×434 cycles. Then PARITY=1 (odd), push 0x03 -> parity bit 1.
- Push 3 words back-to-back (0xA5, 0x00, 0xFF) -> three contiguous frames, no idle cycle between stop and next start, busy stays high throughout.
- FIFO_DEPTH=4, valid held high with 6 words while frame 1 transmits -> data_in_ready low once level=4, no word lost or duplicated, all 6 bytes received in order.
- Simultaneous push and pop at level 2 -> fifo_level remains 2.
- Reset asserted during the data bits of 0x3C with 2 words queued -> uart_tx=1, busy=0, level=0 immediately; after release the line stays idle until a new push.
